screen_phase_sequencer: RTL and testbench

//  Consumer of the one-hot screen-phase word from the game-flow controller. Tracks the displayed

---
 rtl/screen_phase_sequencer_if.sv | 20 ++
 rtl/screen_phase_sequencer.sv | 128 ++++++++++++
 tb/tb_screen_phase_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/screen_phase_sequencer_if.sv
// screen_phase_sequencer_if: phase/frame inputs and display-control outputs of the screen-phase sequencer
interface screen_phase_sequencer_if;
  logic [3:0] phase;
  logic       frame_start;
  logic [1:0] bg_sel;
  logic [3:0] brightness;
  logic       busy;
  logic       game_run;
  logic       blink_on;
  logic       hold_done;
  logic       phase_err;
  modport master (
    output phase, frame_start,
    input  bg_sel, brightness, busy, game_run, blink_on, hold_done, phase_err
  );
  modport slave (
    input  phase, frame_start,
    output bg_sel, brightness, busy, game_run, blink_on, hold_done, phase_err
  );
endinterface

// File: rtl/screen_phase_sequencer.sv
// screen_phase_sequencer: tracks the displayed screen phase, fades between screens per frame, blinks the title prompt and times the DEAD/END hold
module screen_phase_sequencer #(
  parameter int FADE_STEP    = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int HOLD_FRAMES  = 180,
  parameter int CNT_W        = 8
) (
  input logic                      CLK,
  input logic                      RESET,
  screen_phase_sequencer_if.slave  sp
);
  typedef enum logic [1:0] {STEADY, FADE_OUT, FADE_IN} state_t;
  localparam logic [3:0] STEP = 4'(FADE_STEP);
  localparam logic [3:0] HI = 4'(15 - FADE_STEP);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_FRAMES);
  state_t state_q, state_d;
  logic [3:0] cur_q, cur_d, tgt_q, tgt_d, bri_q, bri_d;
  logic [1:0] bg_q, bg_d;
  logic busy_q, busy_d, run_q, run_d, blink_q, blink_d;
  logic hold_q, hold_d, err_q, err_d, fired_q, fired_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic valid;
  assign valid = (sp.phase != 4'd0) && ((sp.phase & (sp.phase - 4'd1)) == 4'd0);
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    tgt_d = tgt_q;
    bri_d = bri_q;
    bg_d = bg_q;
    busy_d = busy_q;
    run_d = run_q;
    blink_d = blink_q;
    fired_d = fired_q;
    cnt_d = cnt_q;
    hold_d = 1'b0;
    err_d = !valid;
    case (state_q)
      STEADY: begin
        if (valid && sp.phase != cur_q) begin
          tgt_d = sp.phase;
          state_d = FADE_OUT;
          busy_d = 1'b1;
          run_d = 1'b0;
          cnt_d = '0;
        end else if (valid) begin
          if (cur_q[3]) begin
            if (sp.frame_start) begin
              blink_d = (cnt_q == BLINK_LAST) ? !blink_q : blink_q;
              cnt_d = (cnt_q == BLINK_LAST) ? '0 : cnt_q + 1'b1;
            end
          end else if (cur_q[2]) begin
            cnt_d = '0;
            blink_d = 1'b1;
          end else if (sp.frame_start && cnt_q != HOLD_END) begin
            cnt_d = cnt_q + 1'b1;
            hold_d = (cnt_q == HOLD_LAST) && !fired_q;
            fired_d = fired_q || (cnt_q == HOLD_LAST);
          end
        end
      end
      FADE_OUT: begin
        if (sp.frame_start) begin
          if (bri_q <= STEP) begin
            bri_d = 4'd0;
            cur_d = tgt_q;
            bg_d = {tgt_q[1] | tgt_q[0], tgt_q[2] | tgt_q[0]};
            state_d = FADE_IN;
          end else begin
            bri_d = bri_q - STEP;
          end
        end
      end
      default: begin
        if (sp.frame_start) begin
          if (bri_q >= HI) begin
            bri_d = 4'd15;
            state_d = STEADY;
            busy_d = 1'b0;
            run_d = cur_q[2];
            blink_d = 1'b1;
            cnt_d = '0;
            fired_d = 1'b0;
          end else begin
            bri_d = bri_q + STEP;
          end
        end
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= STEADY;
      cur_q <= 4'b1000;
      tgt_q <= 4'b1000;
      bri_q <= 4'd15;
      bg_q <= 2'd0;
      busy_q <= 1'b0;
      run_q <= 1'b0;
      blink_q <= 1'b1;
      hold_q <= 1'b0;
      err_q <= 1'b0;
      fired_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      tgt_q <= tgt_d;
      bri_q <= bri_d;
      bg_q <= bg_d;
      busy_q <= busy_d;
      run_q <= run_d;
      blink_q <= blink_d;
      hold_q <= hold_d;
      err_q <= err_d;
      fired_q <= fired_d;
      cnt_q <= cnt_d;
    end
  end
  assign sp.bg_sel = bg_q;
  assign sp.brightness = bri_q;
  assign sp.busy = busy_q;
  assign sp.game_run = run_q;
  assign sp.blink_on = blink_q;
  assign sp.hold_done = hold_q;
  assign sp.phase_err = err_q;
endmodule

// File: tb/tb_screen_phase_sequencer.sv
// tb_screen_phase_sequencer: scoreboard bench for the screen-phase sequencer
module tb_screen_phase_sequencer;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;
  exp_t sb[$];
  screen_phase_sequencer_if sp();
  screen_phase_sequencer dut (.CLK(CLK), .RESET(RESET), .sp(sp));
  always #5 CLK = ~CLK;
  function automatic int obs(input int s);
    case (s)
      0: return int'(sp.bg_sel);
      1: return int'(sp.brightness);
      2: return int'(sp.busy);
      3: return int'(sp.game_run);
      4: return int'(sp.blink_on);
      5: return int'(sp.hold_done);
      default: return int'(sp.phase_err);
    endcase
  endfunction
  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic expect_out(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic tick(input logic fs);
    exp_t e;
    sp.frame_start = fs;
    @(posedge CLK);
    #1;
    sp.frame_start = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.val);
    end
  endtask
  task automatic run_fade(input string tag, input logic [3:0] ph, input int bg_new, input int run_new);
    int bri_tab[8] = '{11, 7, 3, 0, 4, 8, 12, 15};
    sp.phase = ph;
    expect_out({tag, "_start_busy"}, 2, 1);
    expect_out({tag, "_start_run"}, 3, 0);
    expect_out({tag, "_start_bri"}, 1, 15);
    tick(1'b1);
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("%s_bri%0d", tag, i), 1, bri_tab[i]);
      expect_out($sformatf("%s_busy%0d", tag, i), 2, i == 7 ? 0 : 1);
      if (i >= 3) expect_out($sformatf("%s_bg%0d", tag, i), 0, bg_new);
      if (i == 7) expect_out({tag, "_run"}, 3, run_new);
      tick(1'b1);
      if (i < 7) begin
        expect_out($sformatf("%s_hold_bri%0d", tag, i), 1, bri_tab[i]);
        tick(1'b0);
      end
    end
  endtask
  initial begin
    int bri_tab[8] = '{11, 7, 3, 0, 4, 8, 12, 15};
    sp.phase = 4'b1000;
    sp.frame_start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    expect_out("rst_bg", 0, 0);
    expect_out("rst_bri", 1, 15);
    expect_out("rst_busy", 2, 0);
    expect_out("rst_run", 3, 0);
    expect_out("rst_blink", 4, 1);
    expect_out("rst_hold", 5, 0);
    expect_out("rst_err", 6, 0);
    tick(1'b0);
    run_fade("to_game", 4'b0100, 1, 1);
    sp.phase = 4'b0010;
    expect_out("g2d_busy", 2, 1);
    expect_out("g2d_run", 3, 0);
    tick(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) sp.phase = 4'b0001;
      expect_out($sformatf("g2d_bri%0d", i), 1, bri_tab[i]);
      if (i >= 3) expect_out($sformatf("g2d_bg%0d", i), 0, 2);
      if (i == 7) expect_out("g2d_end_busy", 2, 0);
      if (i == 7) expect_out("g2d_end_run", 3, 0);
      tick(1'b1);
    end
    expect_out("d2e_busy", 2, 1);
    expect_out("d2e_bg", 0, 2);
    tick(1'b0);
    for (int i = 0; i < 8; i++) begin
      expect_out($sformatf("d2e_bri%0d", i), 1, bri_tab[i]);
      if (i >= 3) expect_out($sformatf("d2e_bg%0d", i), 0, 3);
      tick(1'b1);
    end
    expect_out("d2e_end_busy", 2, 0);
    tick(1'b0);
    sp.phase = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      expect_out($sformatf("inv_err%0d", i), 6, 1);
      expect_out($sformatf("inv_busy%0d", i), 2, 0);
      expect_out($sformatf("inv_bg%0d", i), 0, 3);
      tick(1'b0);
    end
    sp.phase = 4'b0000;
    expect_out("zero_err", 6, 1);
    expect_out("zero_busy", 2, 0);
    tick(1'b0);
    sp.phase = 4'b0001;
    expect_out("same_err", 6, 0);
    expect_out("same_busy", 2, 0);
    tick(1'b1);
    run_fade("to_start", 4'b1000, 0, 0);
    for (int k = 1; k <= 90; k++) begin
      expect_out($sformatf("blink_f%0d", k), 4, ((k / 30) % 2 == 0) ? 1 : 0);
      tick(1'b1);
    end
    run_fade("to_dead", 4'b0010, 2, 0);
    for (int k = 1; k <= 400; k++) begin
      expect_out($sformatf("hold_f%0d", k), 5, k == 180 ? 1 : 0);
      tick(1'b1);
    end
    sp.phase = 4'b1000;
    tick(1'b0);
    tick(1'b1);
    expect_out("mid_bri", 1, 7);
    tick(1'b1);
    RESET = 1'b1;
    expect_out("mrst_bg", 0, 0);
    expect_out("mrst_bri", 1, 15);
    expect_out("mrst_busy", 2, 0);
    expect_out("mrst_run", 3, 0);
    expect_out("mrst_blink", 4, 1);
    expect_out("mrst_hold", 5, 0);
    tick(1'b1);
    RESET = 1'b0;
    expect_out("post_busy", 2, 0);
    expect_out("post_bri", 1, 15);
    tick(1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
